// File: rtl/mio_bus_ctrl.sv
// mio_bus_ctrl: CPU memory/IO bus controller.
// Routes each access to RAM, GPIO, timer or unmapped; acks via MIO_ready.
module mio_bus_ctrl #(
  parameter int RAM_AW  = 10,
  parameter int RAM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              MIO_ready,
  output logic              INT,
  output logic [RAM_AW-1:0] ram_addr,
  output logic              ram_we,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  input  logic [15:0]       sw,
  output logic [15:0]       led
);

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    RESP
  } state_t;

  typedef enum logic [2:0] {
    T_RAM,
    T_GPIO,
    T_CNT,
    T_CTRL,
    T_NONE
  } tgt_t;

  localparam logic [1:0] WAIT_INIT =
    2'(RAM_LAT - 1);

  state_t      state;
  tgt_t        req_tgt;
  tgt_t        acc_tgt;
  logic        acc_we;
  logic [1:0]  wait_cnt;

  logic [15:0] sw_meta;
  logic [15:0] sw_sync;

  logic [31:0] count;
  logic [31:0] reload;
  logic        cnt_en;
  logic        irq_en;
  logic        pending;

  logic        go;
  logic        wr_led;
  logic        wr_cnt;
  logic        wr_ctrl;
  logic        tick_zero;
  logic [31:0] rd_val;

  always_comb begin
    req_tgt = T_NONE;
    unique case (1'b1)
      cpu_addr[31:28] == 4'h0:
        req_tgt = T_RAM;
      cpu_addr[31:28] == 4'hE &&
      cpu_addr[27:0] == 28'h0:
        req_tgt = T_GPIO;
      cpu_addr[31:28] == 4'hF &&
      cpu_addr[27:0] == 28'h0:
        req_tgt = T_CNT;
      cpu_addr[31:28] == 4'hF &&
      cpu_addr[27:0] == 28'h4:
        req_tgt = T_CTRL;
      default: req_tgt = T_NONE;
    endcase
  end

  assign go = (state == IDLE) && cpu_req;

  assign wr_led =
    go && cpu_we && (req_tgt == T_GPIO);
  assign wr_cnt =
    go && cpu_we && (req_tgt == T_CNT);
  assign wr_ctrl =
    go && cpu_we && (req_tgt == T_CTRL);

  assign tick_zero =
    cnt_en && (count == 32'h0);

  always_comb begin
    rd_val = 32'h0;
    unique case (acc_tgt)
      T_GPIO:  rd_val = {16'h0, sw_sync};
      T_CNT:   rd_val = count;
      T_CTRL:  rd_val = {29'h0, pending,
                         irq_en, cnt_en};
      default: rd_val = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      acc_tgt   <= T_NONE;
      acc_we    <= 1'b0;
      wait_cnt  <= 2'd0;
      cpu_rdata <= 32'h0;
      MIO_ready <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= 32'h0;
    end else begin
      MIO_ready <= 1'b0;
      ram_we    <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cpu_req) begin
            acc_tgt  <= req_tgt;
            acc_we   <= cpu_we;
            wait_cnt <= WAIT_INIT;
            state    <= ACC;
            if (req_tgt == T_RAM) begin
              ram_addr  <=
                cpu_addr[RAM_AW+1:2];
              ram_wdata <= cpu_wdata;
              ram_we    <= cpu_we;
            end
          end
        end
        ACC: begin
          if (acc_tgt == T_RAM && !acc_we) begin
            if (wait_cnt == 2'd0) begin
              cpu_rdata <= ram_rdata;
              state     <= RESP;
            end else begin
              wait_cnt <= wait_cnt - 2'd1;
            end
          end else begin
            cpu_rdata <= rd_val;
            state     <= RESP;
          end
        end
        RESP: begin
          MIO_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sw_meta <= 16'h0;
      sw_sync <= 16'h0;
      led     <= 16'h0;
    end else begin
      sw_meta <= sw;
      sw_sync <= sw_meta;
      if (wr_led) begin
        led <= cpu_wdata[15:0];
      end
    end
  end

  // A zero-reload sets pending even if a clear lands on the same edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count   <= 32'h0;
      reload  <= 32'h0;
      cnt_en  <= 1'b0;
      irq_en  <= 1'b0;
      pending <= 1'b0;
      INT     <= 1'b0;
    end else begin
      if (wr_cnt) begin
        count  <= cpu_wdata;
        reload <= cpu_wdata;
      end else if (cnt_en) begin
        if (count == 32'h0) begin
          count <= reload;
        end else begin
          count <= count - 32'd1;
        end
      end
      if (wr_ctrl) begin
        cnt_en <= cpu_wdata[0];
        irq_en <= cpu_wdata[1];
      end
      if (tick_zero) begin
        pending <= 1'b1;
      end else if (wr_ctrl && cpu_wdata[2]) begin
        pending <= 1'b0;
      end
      INT <= pending & irq_en;
    end
  end

endmodule
